// File: rtl/tbec_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tbec_pkg                                                           |
// | Shared types and geometry for the TBEC-protected 256x32 memory.    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package tbec_pkg;

  localparam int TBEC_DATA_W = 16;
  localparam int TBEC_CODE_W = 32;
  localparam int TBEC_ADDR_W = 8;
  localparam int TBEC_CHK_W  = 5;

  // Codeword positions (1..31, powers of two excluded) holding the data
  // bits; position 0 is overall parity, powers of two are Hamming checks,
  // unused non-power positions are held at zero.
  localparam int TBEC_DATA_POS [TBEC_DATA_W] =
    '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21};

  typedef enum logic [1:0] {
    CLEAN  = 2'b00,
    CORR   = 2'b01,
    UNCORR = 2'b10,
    RSVD   = 2'b11
  } err_code_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WB   = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tbec_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tbec_decoder                                                       |
// | Extended Hamming decoder: corrects one bit, flags two-bit errors.  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tbec_decoder
  import tbec_pkg::*;
(
  input  logic [TBEC_CODE_W-1:0] i_code,
  output logic [TBEC_DATA_W-1:0] o_data,
  output err_code_t              o_err
);

  logic [TBEC_CHK_W-1:0]  w_syn;
  logic                   w_par;
  logic [TBEC_CODE_W-1:0] w_fixed;

  function automatic logic [TBEC_CHK_W-1:0] f_syndrome(input logic [TBEC_CODE_W-1:0] cw);
    logic [TBEC_CHK_W-1:0] s;
    s = '0;
    for (int p = 1; p < TBEC_CODE_W; p++) begin
      if (cw[p]) begin
        s = s ^ TBEC_CHK_W'(p);
      end
    end
    return s;
  endfunction

  // Odd parity means one flipped bit (at the syndrome position, 0 = parity
  // bit); even parity with a non-zero syndrome means two flipped bits.
  always_comb begin
    w_syn   = f_syndrome(i_code);
    w_par   = ^i_code;
    w_fixed = i_code;
    o_err   = CLEAN;
    if (w_par) begin
      w_fixed[w_syn] = ~i_code[w_syn];
      o_err          = CORR;
    end else if (w_syn != '0) begin
      o_err = UNCORR;
    end
    o_data = '0;
    for (int i = 0; i < TBEC_DATA_W; i++) begin
      o_data[i] = w_fixed[TBEC_DATA_POS[i]];
    end
  end

endmodule
`default_nettype wire

// File: rtl/tbec_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tbec_encoder                                                       |
// | Extended Hamming (SECDED) encoder, 16 data bits -> 32-bit word.    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tbec_encoder
  import tbec_pkg::*;
(
  input  logic [TBEC_DATA_W-1:0] i_data,
  output logic [TBEC_CODE_W-1:0] o_code
);

  function automatic logic [TBEC_CODE_W-1:0] f_encode(input logic [TBEC_DATA_W-1:0] d);
    logic [TBEC_CODE_W-1:0] cw;
    logic                   chk;
    cw = '0;
    for (int i = 0; i < TBEC_DATA_W; i++) begin
      cw[TBEC_DATA_POS[i]] = d[i];
    end
    // Check bit c covers every position whose index has bit c set
    for (int c = 0; c < TBEC_CHK_W; c++) begin
      chk = 1'b0;
      for (int p = 1; p < TBEC_CODE_W; p++) begin
        if (((p >> c) & 1) == 1) begin
          chk = chk ^ cw[p];
        end
      end
      cw[1 << c] = chk;
    end
    cw[0] = ^cw[TBEC_CODE_W-1:1];
    return cw;
  endfunction

  assign o_code = f_encode(i_data);

endmodule
`default_nettype wire

// File: rtl/tbec_memory.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tbec_memory                                                        |
// | 256x32 single-port RAM, registered read, contents not reset.       |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tbec_memory
  import tbec_pkg::*;
(
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [TBEC_ADDR_W-1:0] i_addr,
  input  logic [TBEC_CODE_W-1:0] i_wdata,
  output logic [TBEC_CODE_W-1:0] o_rdata
);

  logic [TBEC_CODE_W-1:0] r_mem [2**TBEC_ADDR_W];
  logic [TBEC_CODE_W-1:0] r_rdata;

  // Write on we; read data appears the cycle after the address
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/tbec_scrub_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tbec_scrub_timer                                                   |
// | Scrub interval counter, pending-step flag and scrub address ptr.   |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tbec_scrub_timer
  import tbec_pkg::*;
#(
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_scrub_en,
  input  logic                   i_issue,
  input  logic                   i_step_done,
  output logic                   o_scrub_pend,
  output logic [TBEC_ADDR_W-1:0] o_scrub_ptr
);

  localparam int TMR_W = $clog2(SCRUB_INTERVAL);
  localparam logic [TMR_W-1:0] c_last = TMR_W'(SCRUB_INTERVAL - 1);

  logic [TMR_W-1:0]       r_timer;
  logic                   r_pend;
  logic [TBEC_ADDR_W-1:0] r_ptr;
  logic                   w_expire;

  assign w_expire = i_scrub_en && (r_timer == c_last);

  // Interval counter: runs only while enabled, cleared when disabled
  always_ff @(posedge clk) begin
    if (rst || !i_scrub_en || (r_timer == c_last)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  // Pending flag: expiry sets it (no queueing), issuing the read clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= (r_pend && !i_issue) || w_expire;
    end
  end

  // Scrub address advances once per completed read, wrapping naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_step_done) begin
      r_ptr <= r_ptr + TBEC_ADDR_W'(1);
    end
  end

  assign o_scrub_pend = r_pend;
  assign o_scrub_ptr  = r_ptr;

endmodule
`default_nettype wire

// File: rtl/tbec_scrub_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tbec_scrub_ctrl                                                    |
// | Host/scrub arbitration, ECC read-repair FSM and event reporting    |
// | for the TBEC-protected 256x32 memory.                              |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tbec_scrub_ctrl
  import tbec_pkg::*;
#(
  parameter int SCRUB_INTERVAL = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                   tbec_clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [TBEC_ADDR_W-1:0] req_addr,
  input  logic [TBEC_DATA_W-1:0] req_wdata,
  output logic                   rsp_valid,
  output logic [TBEC_DATA_W-1:0] rsp_rdata,
  output logic [1:0]             rsp_error_code,
  input  logic                   scrub_en,
  output logic                   scrub_busy,
  output logic [CNT_W-1:0]       corr_count,
  output logic [CNT_W-1:0]       uncorr_count,
  output logic                   uncorr_flag,
  output logic [TBEC_ADDR_W-1:0] uncorr_addr
);

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_is_scrub;
  logic [TBEC_ADDR_W-1:0] r_addr;
  logic [TBEC_DATA_W-1:0] r_wb_data;

  logic                   r_rsp_valid;
  logic [TBEC_DATA_W-1:0] r_rsp_rdata;
  err_code_t              r_rsp_code;
  logic [CNT_W-1:0]       r_corr_cnt;
  logic [CNT_W-1:0]       r_uncorr_cnt;
  logic                   r_uncorr_flag;
  logic [TBEC_ADDR_W-1:0] r_uncorr_addr;

  logic                   w_scrub_pend;
  logic [TBEC_ADDR_W-1:0] w_scrub_ptr;
  logic                   w_issue_scrub;
  logic                   w_host_rd_acc;
  logic                   w_step_done;
  logic                   w_we_req;
  logic                   w_mem_we;
  logic [TBEC_ADDR_W-1:0] w_mem_addr;
  logic [TBEC_DATA_W-1:0] w_enc_in;
  logic [TBEC_CODE_W-1:0] w_enc_out;
  logic [TBEC_CODE_W-1:0] w_mem_rdata;
  logic [TBEC_DATA_W-1:0] w_dec_data;
  err_code_t              w_dec_code;
  logic                   w_dec_bad;

  tbec_encoder u_enc (
    .i_data (w_enc_in),
    .o_code (w_enc_out)
  );

  tbec_memory u_mem (
    .clk     (tbec_clk),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (w_enc_out),
    .o_rdata (w_mem_rdata)
  );

  tbec_decoder u_dec (
    .i_code (w_mem_rdata),
    .o_data (w_dec_data),
    .o_err  (w_dec_code)
  );

  tbec_scrub_timer #(
    .SCRUB_INTERVAL (SCRUB_INTERVAL)
  ) u_timer (
    .clk          (tbec_clk),
    .rst          (rst),
    .i_scrub_en   (scrub_en),
    .i_issue      (w_issue_scrub),
    .i_step_done  (w_step_done),
    .o_scrub_pend (w_scrub_pend),
    .o_scrub_ptr  (w_scrub_ptr)
  );

  assign w_step_done = (r_state == RD) && r_is_scrub;
  assign w_dec_bad   = (w_dec_code == UNCORR) || (w_dec_code == RSVD);
  // Reset wins over any write in flight, including a pending write-back
  assign w_mem_we    = w_we_req && !rst;

  // Next state and memory port steering; a pending scrub outranks the host
  always_comb begin
    w_next_state  = r_state;
    w_we_req      = 1'b0;
    w_mem_addr    = r_addr;
    w_enc_in      = req_wdata;
    w_issue_scrub = 1'b0;
    w_host_rd_acc = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_scrub_pend) begin
          w_mem_addr    = w_scrub_ptr;
          w_issue_scrub = 1'b1;
          w_next_state  = RD;
        end else if (req_valid) begin
          w_mem_addr = req_addr;
          if (req_we) begin
            w_we_req = 1'b1;
          end else begin
            w_host_rd_acc = 1'b1;
            w_next_state  = RD;
          end
        end
      end
      RD: begin
        w_next_state = (w_dec_code == CORR) ? WB : IDLE;
      end
      WB: begin
        w_we_req     = 1'b1;
        w_enc_in     = r_wb_data;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register plus the address/source/data of the access in flight
  always_ff @(posedge tbec_clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_is_scrub <= 1'b0;
      r_addr     <= '0;
      r_wb_data  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_issue_scrub || w_host_rd_acc) begin
        r_addr     <= w_mem_addr;
        r_is_scrub <= w_issue_scrub;
      end
      if (r_state == RD) begin
        r_wb_data <= w_dec_data;
      end
    end
  end

  // Host read response: registered from the decoder, one-cycle pulse
  always_ff @(posedge tbec_clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_code  <= CLEAN;
    end else begin
      r_rsp_valid <= (r_state == RD) && !r_is_scrub;
      if ((r_state == RD) && !r_is_scrub) begin
        r_rsp_rdata <= w_dec_data;
        r_rsp_code  <= w_dec_code;
      end
    end
  end

  // Saturating event counters and sticky uncorrectable capture
  always_ff @(posedge tbec_clk) begin
    if (rst) begin
      r_corr_cnt    <= '0;
      r_uncorr_cnt  <= '0;
      r_uncorr_flag <= 1'b0;
      r_uncorr_addr <= '0;
    end else if (r_state == RD) begin
      if ((w_dec_code == CORR) && (r_corr_cnt != '1)) begin
        r_corr_cnt <= r_corr_cnt + CNT_W'(1);
      end
      if (w_dec_bad) begin
        if (r_uncorr_cnt != '1) begin
          r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
        end
        r_uncorr_flag <= 1'b1;
        r_uncorr_addr <= r_addr;
      end
    end
  end

  assign req_ready      = (r_state == IDLE) && !w_scrub_pend;
  assign scrub_busy     = ((r_state == RD) || (r_state == WB)) && r_is_scrub;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = r_rsp_rdata;
  assign rsp_error_code = r_rsp_code;
  assign corr_count     = r_corr_cnt;
  assign uncorr_count   = r_uncorr_cnt;
  assign uncorr_flag    = r_uncorr_flag;
  assign uncorr_addr    = r_uncorr_addr;

endmodule
`default_nettype wire

// File: tb/tb_tbec_scrub_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tbec_scrub_ctrl                                                 |
// | Self-checking bench: directed cases plus random host traffic and   |
// | fault injection against a per-word data/fault-count model.         |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_tbec_scrub_ctrl;

  localparam int CNT_W = 16;

  logic             tbec_clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [7:0]       req_addr;
  logic [15:0]      req_wdata;
  logic             rsp_valid;
  logic [15:0]      rsp_rdata;
  logic [1:0]       rsp_error_code;
  logic             scrub_en;
  logic             scrub_busy;
  logic [CNT_W-1:0] corr_count;
  logic [CNT_W-1:0] uncorr_count;
  logic             uncorr_flag;
  logic [7:0]       uncorr_addr;

  always #5 tbec_clk = ~tbec_clk;

  tbec_scrub_ctrl #(.SCRUB_INTERVAL(4), .CNT_W(CNT_W)) u_dut (
    .tbec_clk       (tbec_clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_error_code (rsp_error_code),
    .scrub_en       (scrub_en),
    .scrub_busy     (scrub_busy),
    .corr_count     (corr_count),
    .uncorr_count   (uncorr_count),
    .uncorr_flag    (uncorr_flag),
    .uncorr_addr    (uncorr_addr)
  );

  // Model: what each word should decode to and how many bits are flipped
  logic [15:0] m_data  [256];
  int          m_flips [256];
  int          m_corr;
  int          m_uncorr;
  logic        m_flag;
  logic [7:0]  m_uaddr;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitors: scrub steps (busy rising edges) and rsp pulses
  int   steps_seen = 0;
  int   rsp_seen   = 0;
  logic busy_q     = 1'b0;
  always @(posedge tbec_clk) begin
    busy_q <= scrub_busy;
    if (scrub_busy && !busy_q) steps_seen <= steps_seen + 1;
    if (rsp_valid) rsp_seen <= rsp_seen + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge tbec_clk);
    #1;
  endtask

  task automatic model_reset();
    m_corr   = 0;
    m_uncorr = 0;
    m_flag   = 1'b0;
    m_uaddr  = 8'd0;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_corr"},   32'(corr_count),   32'(m_corr));
    check_eq({tag, "_uncorr"}, 32'(uncorr_count), 32'(m_uncorr));
    check_eq({tag, "_flag"},   32'(uncorr_flag),  32'(m_flag));
    if (m_flag) check_eq({tag, "_uaddr"}, 32'(uncorr_addr), 32'(m_uaddr));
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ready"}, 32'(req_ready),      32'd1);
    check_eq({tag, "_rspv"},  32'(rsp_valid),      32'd0);
    check_eq({tag, "_rdata"}, 32'(rsp_rdata),      32'd0);
    check_eq({tag, "_code"},  32'(rsp_error_code), 32'd0);
    check_eq({tag, "_busy"},  32'(scrub_busy),     32'd0);
    check_eq({tag, "_uaddr"}, 32'(uncorr_addr),    32'd0);
    check_status(tag);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      cyc();
      n++;
    end
    if (!req_ready) check_eq("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic host_write(input int a, input logic [15:0] d);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 8'(a);
    req_wdata = d;
    wait_ready();
    cyc();
    req_valid  = 1'b0;
    m_data[a]  = d;
    m_flips[a] = 0;
  endtask

  task automatic flip_mask(input int a, input logic [31:0] mask, input int nbits);
    u_dut.u_mem.r_mem[a] = u_dut.u_mem.r_mem[a] ^ mask;
    m_flips[a] += nbits;
  endtask

  task automatic flip_random(input int a, input int nbits);
    int b1;
    int b2;
    logic [31:0] mask;
    b1   = $urandom_range(0, 31);
    b2   = (b1 + 1 + $urandom_range(0, 30)) % 32;
    mask = 32'd1 << b1;
    if (nbits == 2) mask = mask | (32'd1 << b2);
    flip_mask(a, mask, nbits);
  endtask

  // Host read with response timing checks; optional reset during write-back
  task automatic host_read(input int a, input bit rst_in_wb);
    int f;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'(a);
    wait_ready();
    cyc();
    req_valid = 1'b0;
    check_eq("rsp_early", 32'(rsp_valid), 32'd0);
    cyc();
    f = m_flips[a];
    check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("rsp_code", 32'(rsp_error_code), (f == 0) ? 32'd0 : (f == 1) ? 32'd1 : 32'd2);
    if (f < 2) check_eq("rsp_rdata", 32'(rsp_rdata), 32'(m_data[a]));
    if (f == 1) begin
      check_eq("wb_ready_low", 32'(req_ready), 32'd0);
      m_corr++;
      m_flips[a] = 0;
    end else if (f >= 2) begin
      m_uncorr++;
      m_flag  = 1'b1;
      m_uaddr = 8'(a);
    end
    if (rst_in_wb) begin
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      model_reset();
      m_flips[a] = f;
      check_reset_vals("rst_wb");
    end else begin
      cyc();
      check_eq("rsp_pulse_len", 32'(rsp_valid), 32'd0);
      check_status("after_rd");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap;
    int          s0;
    int          r0;
    int          n;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'd0;
    req_wdata = 16'd0;
    scrub_en  = 1'b0;
    model_reset();
    for (int i = 0; i < 256; i++) m_flips[i] = 0;
    cyc(); cyc(); cyc();
    check_reset_vals("reset");
    rst = 1'b0;

    // Give every word known contents
    for (int a = 0; a < 256; a++) host_write(a, 16'($urandom));

    // Basic write/read
    host_write(5, 16'h1234);
    host_read(5, 1'b0);

    // Single-bit fault corrected on host read, then clean
    host_write(7, 16'hBEEF);
    flip_mask(7, 32'h0000_0008, 1);
    host_read(7, 1'b0);
    host_read(7, 1'b0);

    // Double-bit fault: flagged, never written back
    host_write(9, 16'h5A5A);
    flip_mask(9, 32'h0002_0010, 2);
    snap = u_dut.u_mem.r_mem[9];
    host_read(9, 1'b0);
    check_eq("uncorr_mem_unchanged", u_dut.u_mem.r_mem[9], snap);

    // Back-to-back writes keep req_ready high
    req_valid = 1'b1;
    req_we    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr  = 8'(40 + i);
      req_wdata = 16'(16'hC000 + i);
      check_eq("wr_b2b_ready", 32'(req_ready), 32'd1);
      cyc();
      m_data[40 + i]  = 16'(16'hC000 + i);
      m_flips[40 + i] = 0;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) host_read(40 + i, 1'b0);

    // Random traffic with fault injection
    for (int it = 0; it < 80; it++) begin
      int op;
      int a;
      op = $urandom_range(0, 2);
      a  = $urandom_range(0, 255);
      if (op == 0) host_write(a, 16'($urandom));
      else if (op == 2 && m_flips[a] == 0) flip_random(a, $urandom_range(1, 2));
      else host_read(a, 1'b0);
    end

    // Scrubber: fresh reset, clean memory, one fault at address 0
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_reset();
    for (int a = 0; a < 256; a++) host_write(a, 16'($urandom));
    flip_random(0, 1);
    s0 = steps_seen;
    r0 = rsp_seen;
    scrub_en = 1'b1;
    n = 0;
    while (corr_count != 1 && n < 200) begin
      cyc();
      n++;
    end
    m_corr     = 1;
    m_flips[0] = 0;
    check_eq("scrub_corr", 32'(corr_count), 32'd1);
    n = 0;
    while (!((steps_seen - s0) >= 256 && !scrub_busy) && n < 5000) begin
      cyc();
      n++;
    end
    check_eq("scrub_steps_done", ((steps_seen - s0) >= 256) ? 32'd1 : 32'd0, 32'd1);
    check_eq("scrub_ptr_wrap", 32'(u_dut.u_timer.o_scrub_ptr), 32'(8'(steps_seen - s0)));
    check_eq("scrub_no_rsp", 32'(rsp_seen - r0), 32'd0);
    check_status("scrub");
    host_read(0, 1'b0);

    // Scrub priority over a waiting host read
    scrub_en = 1'b0;
    cyc(); cyc();
    wait_ready();
    host_write(33, 16'h0F0F);
    scrub_en = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'd33;
    scrub_en  = 1'b0;
    check_eq("prio_ready_low", 32'(req_ready), 32'd0);
    check_eq("prio_busy_pre", 32'(scrub_busy), 32'd0);
    cyc();
    check_eq("prio_scrub_first", 32'(scrub_busy), 32'd1);
    check_eq("prio_ready_busy", 32'(req_ready), 32'd0);
    host_read(33, 1'b0);

    // Reset during write-back suppresses the repair
    host_write(20, 16'hA55A);
    flip_random(20, 1);
    snap = u_dut.u_mem.r_mem[20];
    host_read(20, 1'b1);
    check_eq("rst_wb_mem_kept", u_dut.u_mem.r_mem[20], snap);
    host_read(20, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
